// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns LSU stores to the LCD window into HD44780-style write cycles
// and reports busy/overrun/fifo_full status. Optional command FIFO: LCD_FIFO_EN.
`default_nettype none

module lcd_ctrl #(
    parameter int SETUP_CYC     = 4,
    parameter int PULSE_CYC     = 25,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 2000,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_wr,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic [31:0] o_status
);

    localparam int CW = $clog2(LONG_EXEC_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [7:0]      r_data;
    logic            r_rs, r_en, r_on, r_busy, r_overrun;
    logic            w_en_nxt, w_long;

    logic            w_ctrl, w_data_wr, w_start, w_drop, w_full, w_pending_nxt;
    logic [8:0]      w_word;
    logic            w_unused;

    assign w_ctrl    = i_lcd_word[31];
    assign w_data_wr = i_lcd_wr & ~w_ctrl;
    assign w_unused  = &{1'b0, i_lcd_word[30:9]};

`ifdef LCD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_fcnt, w_fcnt_nxt;
    logic            w_push, w_pop;

    assign w_full        = (r_fcnt == (AW+1)'(FIFO_DEPTH));
    // A full FIFO drops the push even when a pop frees a slot this cycle.
    assign w_push        = w_data_wr & ~w_full;
    assign w_drop        = w_data_wr & w_full;
    assign w_pop         = (r_state == S_IDLE) && (r_fcnt != '0);
    assign w_start       = w_pop;
    assign w_word        = r_mem[r_rptr];
    assign w_fcnt_nxt    = r_fcnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_pending_nxt = (w_fcnt_nxt != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_lcd_word[8:0];
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_fcnt <= w_fcnt_nxt;
        end
    end
`else
    assign w_full        = 1'b0;
    assign w_start       = w_data_wr && (r_state == S_IDLE);
    assign w_drop        = w_data_wr && (r_state != S_IDLE);
    assign w_word        = i_lcd_word[8:0];
    assign w_pending_nxt = 1'b0;
`endif

    // Clear-display (0x01) and return-home (0x02/0x03) need the long wait.
    assign w_long = ~r_rs && ((r_data[7:1] == 7'b0000000) || (r_data[7:1] == 7'b0000001));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = CW'(PULSE_CYC - 1);
                    w_en_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_PULSE: begin
                w_en_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYC - 1);
                    w_en_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_long ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_rs      <= 1'b0;
            r_en      <= 1'b0;
            r_on      <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || w_pending_nxt;
            if (w_start) begin
                r_data <= w_word[7:0];
                r_rs   <= w_word[8];
            end
            if (i_lcd_wr && w_ctrl) begin
                r_on <= i_lcd_word[0];
            end
            if (i_lcd_wr && w_ctrl && i_lcd_word[1]) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_en;
    assign o_lcd_on   = r_on;
    assign o_busy     = r_busy;
    assign o_status   = {29'b0, w_full, r_overrun, r_busy};

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench for lcd_ctrl; a negedge monitor pops expected
// bus transactions as EN pulses appear and checks their shape.
`default_nettype none

module tb_lcd_ctrl;

    localparam int SETUP = 2;
    localparam int PULSE = 3;
    localparam int HOLD  = 1;
    localparam int EXEC  = 5;
    localparam int LONG  = 20;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_lcd_wr = 1'b0;
    logic [31:0] i_lcd_word = '0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy;
    logic [31:0] o_status;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         blen;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lcd_ctrl #(
        .SETUP_CYC    (SETUP),
        .PULSE_CYC    (PULSE),
        .HOLD_CYC     (HOLD),
        .EXEC_CYC     (EXEC),
        .LONG_EXEC_CYC(LONG),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_lcd_wr  (i_lcd_wr),
        .i_lcd_word(i_lcd_word),
        .o_lcd_data(o_lcd_data),
        .o_lcd_rs  (o_lcd_rs),
        .o_lcd_rw  (o_lcd_rw),
        .o_lcd_en  (o_lcd_en),
        .o_lcd_on  (o_lcd_on),
        .o_busy    (o_busy),
        .o_status  (o_status)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: per-transaction EN width, setup lead and busy length.
    logic en_q, busy_q, seen_en;
    int   en_n, busy_n, setup_n, cur_blen;

    always @(negedge clk or posedge i_reset) begin
        if (i_reset) begin
            en_q = 0; busy_q = 0; seen_en = 0;
            en_n = 0; busy_n = 0; setup_n = 0; cur_blen = 0;
        end else begin
            if (o_lcd_en && !en_q) begin
                seen_en = 1;
                if (q.size() == 0) begin
                    check_eq("sb_unexpected_tx", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_eq("tx_data", {24'b0, o_lcd_data}, {24'b0, e.data});
                    check_eq("tx_rs", {31'b0, o_lcd_rs}, {31'b0, e.rs});
                    check_eq("tx_rw", {31'b0, o_lcd_rw}, 32'd0);
`ifndef LCD_FIFO_EN
                    check_eq("tx_setup", setup_n, SETUP);
`endif
                    cur_blen = e.blen;
                end
            end
            if (o_lcd_en) begin
                en_n++;
            end else if (en_q) begin
                check_eq("tx_en_len", en_n, PULSE);
                en_n = 0;
            end
            if (o_busy) busy_n++;
            if (o_busy && !o_lcd_en && !seen_en) setup_n++;
            if (!o_busy && busy_q) begin
`ifndef LCD_FIFO_EN
                check_eq("tx_busy_len", busy_n, cur_blen);
`endif
                busy_n = 0; setup_n = 0; seen_en = 0;
            end
            en_q   = o_lcd_en;
            busy_q = o_busy;
        end
    end

    task automatic lcd_write(input logic [31:0] w);
        @(negedge clk);
        i_lcd_wr   = 1'b1;
        i_lcd_word = w;
        @(negedge clk);
        i_lcd_wr   = 1'b0;
    endtask

    task automatic send_data(input logic [31:0] w, input int exec);
        q.push_back('{w[8], w[7:0], SETUP + PULSE + HOLD + exec});
        lcd_write(w);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!o_busy) done = 1;
        end
        if (!done) check_eq("timeout_idle", 32'd0, 32'd1);
    endtask

    task automatic wait_en(input logic lvl);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (o_lcd_en == lvl) done = 1;
        end
        if (!done) check_eq("timeout_en", 32'd0, 32'd1);
    endtask

    initial begin
        #23;
        check_eq("rst_data", {24'b0, o_lcd_data}, 32'd0);
        check_eq("rst_rs_rw_en_on", {28'b0, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on}, 32'd0);
        check_eq("rst_busy", {31'b0, o_busy}, 32'd0);
        check_eq("rst_status", o_status, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        // Abort in the middle of the EN pulse.
        send_data(32'h0000_0155, EXEC);
        wait_en(1'b1);
        #2 i_reset = 1'b1;
        #1;
        check_eq("abort_en", {31'b0, o_lcd_en}, 32'd0);
        check_eq("abort_data_rs", {23'b0, o_lcd_rs, o_lcd_data}, 32'd0);
        check_eq("abort_status", o_status, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;

        send_data(32'h0000_0141, EXEC);
        wait_idle();
        check_eq("keep_data_rs", {23'b0, o_lcd_rs, o_lcd_data}, 32'h141);
        send_data(32'h0000_0001, LONG);
        wait_idle();
        send_data(32'h0000_0080, EXEC);
        wait_idle();
        send_data(32'h0000_0003, LONG);
        wait_idle();
        send_data(32'h0000_0004, EXEC);
        wait_idle();
        send_data(32'h0000_0101, EXEC);
        wait_idle();

        // Control word while a transaction is in flight.
        send_data(32'h0000_0123, EXEC);
        repeat (2) @(negedge clk);
        lcd_write(32'h8000_0001);
        check_eq("ctrl_on", {31'b0, o_lcd_on}, 32'd1);
        check_eq("ctrl_busy", {31'b0, o_busy}, 32'd1);
        wait_idle();

`ifndef LCD_FIFO_EN
        send_data(32'h0000_0142, EXEC);
        wait_en(1'b1);
        wait_en(1'b0);
        @(negedge clk);
        lcd_write(32'h0000_0143);
        check_eq("drop_status", o_status, 32'h3);
        wait_idle();
        check_eq("drop_status_idle", o_status, 32'h2);
        check_eq("drop_data_kept", {23'b0, o_lcd_rs, o_lcd_data}, 32'h142);
`else
        send_data(32'h0000_0150, EXEC);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            q.push_back('{1'b1, 8'h60 + 8'(i), SETUP + PULSE + HOLD + EXEC});
        end
        @(negedge clk);
        i_lcd_wr   = 1'b1;
        i_lcd_word = 32'h0000_0160;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) check_eq("fifo_full", {31'b0, o_status[2]}, 32'd1);
            i_lcd_word = 32'h0000_0160 + i;
        end
        @(negedge clk);
        i_lcd_wr = 1'b0;
        check_eq("fifo_overrun", {31'b0, o_status[1]}, 32'd1);
        wait_idle();
        check_eq("fifo_status_idle", o_status, 32'h2);
`endif
        lcd_write(32'h8000_0002);
        check_eq("ovr_clear", o_status, 32'h0);
        check_eq("ctrl_off", {31'b0, o_lcd_on}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("sb_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Responder at the far end of the LSU's LCD store path.
- Takes each 32-bit word the core writes to the LCD window (0x1000_4000–0x1000_4FFF) and turns it into one HD44780-style bus transaction (setup, enable pulse, hold, execution wait) on the character-LCD pins.
- Exposes a status word that the LSU load mux returns for reads of the same window, so software can poll busy/overrun.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before EN rises (tAS).
- PULSE_CYC, 25: cycles EN is held high (PW_EH).
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls (tH).
- EXEC_CYC, 2000: execution wait for normal commands and data writes.
- LONG_EXEC_CYC, 82000: execution wait for clear-display / return-home.
- FIFO_DEPTH, 4: command FIFO depth, power of two. Used only with LCD_FIFO_EN.

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_lcd_wr, input, 1: one-cycle strobe; LSU store to the LCD window.
- i_lcd_word, input, 32: store data. [7:0] DATA, [8] RS, [31] CTRL.
- o_lcd_data, output, 8: LCD DB[7:0].
- o_lcd_rs, output, 1: LCD register select.
- o_lcd_rw, output, 1: LCD read/write; tied 0 (write-only).
- o_lcd_en, output, 1: LCD enable.
- o_lcd_on, output, 1: LCD power/backlight.
- o_busy, output, 1: transaction in progress or queued.
- o_status, output, 32: {29'b0, fifo_full, overrun, busy}. fifo_full is 0 without LCD_FIFO_EN.

Behaviour:
- Reset (async, all flops): o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_busy=0, overrun=0, FSM=IDLE, counter=0, FIFO empty. Reset mid-transaction aborts immediately; EN drops in the same instant.
- Control words (i_lcd_wr=1, CTRL=1):
  - Never queued; take effect next edge in any state.
  - o_lcd_on <= word[0]; if word[1]=1, overrun <= 0.
- Data/command words (CTRL=0): start a bus transaction (see Optional Feature for acceptance).
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE. One down-counter, width clog2(LONG_EXEC_CYC+1).
- IDLE with a word accepted: latch o_lcd_data=DATA and o_lcd_rs=RS. Go to SETUP with count=SETUP_CYC-1.
- SETUP: EN=0. At count 0, go to PULSE (count=PULSE_CYC-1) and set EN=1.
- PULSE: EN=1. At count 0, go to HOLD (count=HOLD_CYC-1) and set EN=0.
- HOLD: EN=0, data/RS unchanged. At count 0, go to WAIT with count=EXEC-1.
  - EXEC = LONG_EXEC_CYC when RS=0 and DATA[7:1]==7'b0000000 (0x01 clear) or DATA[7:1]==7'b0000001 (0x02/0x03 home).
  - Otherwise EXEC = EXEC_CYC.
- WAIT: EN=0. At count 0, go to IDLE. o_lcd_data and o_lcd_rs keep their last value in IDLE.
- Timing: busy period is exactly SETUP_CYC+PULSE_CYC+HOLD_CYC+EXEC cycles. EN is high for exactly PULSE_CYC cycles.
- o_busy is registered: 1 whenever FSM!=IDLE, or the FIFO is non-empty.
- overrun is sticky; it is cleared only by reset or by a control word with bit1 set.

Optional Feature:
- Macro: LCD_FIFO_EN.
- Defined:
  - Every non-control word is pushed into a FIFO_DEPTH-entry FIFO; the write is accepted if the FIFO is not full.
  - A push into a full FIFO is dropped and sets overrun, even if a pop occurs in the same cycle.
  - IDLE pops the head when the FIFO is non-empty: write at edge N -> pop at N+1 -> SETUP visible after edge N+2.
  - fifo_full is reported in o_status[2].
- Undefined:
  - No FIFO. A word is accepted only when FSM==IDLE in that cycle; SETUP is visible after edge N+1.
  - A write in any other state, including the last WAIT cycle, is dropped and sets overrun.
  - o_status[2]=0.

Test Plan:
- Test parameters for all scenarios: SETUP=2, PULSE=3, HOLD=1, EXEC=5, LONG=20.
- Reset during PULSE (EN=1) -> all outputs 0, busy=0, and the next write starts a clean transaction.
- Write 0x0000_0141 (RS=1, DATA=0x41) -> DATA=0x41, RS=1; EN high exactly 3 cycles starting 2 cycles after SETUP entry; busy high 11 cycles; RW always 0.
- Write 0x0000_0001 -> WAIT lasts 20 cycles (busy 26 cycles). Write 0x0000_0080 -> WAIT lasts 5 cycles.
- Control word 0x8000_0001 while busy -> o_lcd_on=1 next cycle; the transaction in flight is unaffected.
- No FIFO: second data write during WAIT -> dropped, o_status=0x3 while busy; then 0x8000_0002 -> overrun=0.
- LCD_FIFO_EN: 5 back-to-back data writes -> 4 transactions execute in order, 5th sets overrun; o_status[2]=1 after the 4th push (before the first pop).
